// File: rtl/dcache_axi_pkg.sv
// Shared types and AXI constants for the data-cache refill/writeback bridge.
package dcache_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_RD_DONE,
        ST_AW,
        ST_W,
        ST_B,
        ST_WR_DONE
    } state_t;

    localparam int          LINE_WORDS     = 8;
    localparam logic [2:0]  LAST_BEAT      = 3'(LINE_WORDS - 1);
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
    localparam logic [7:0]  AXI_LEN_LINE   = 8'd7;

endpackage

// File: rtl/dcache_axi_bridge.sv
// Converts data-cache line refill / dirty-line writeback requests into
// single 8-beat AXI4 INCR bursts; one transaction in flight at a time.
module dcache_axi_bridge
    import dcache_axi_pkg::*;
#(
    parameter int         OFFSET_LEN = 5,
    parameter logic [3:0] AXI_ID     = 4'd1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             mem_read_req,
    input  logic [31:0]                      mem_addr,
    output logic [LINE_WORDS-1:0][31:0]      mass_data,
    output logic                             mem_gnt,
    input  logic                             mem_write_req,
    input  logic [31:0]                      wr_addr,
    input  logic [LINE_WORDS-1:0][31:0]      axi_wr,
    output logic                             wr_done,
    output logic [3:0]                       arid,
    output logic [31:0]                      araddr,
    output logic [7:0]                       arlen,
    output logic [2:0]                       arsize,
    output logic [1:0]                       arburst,
    output logic                             arvalid,
    input  logic                             arready,
    input  logic [31:0]                      rdata,
    input  logic                             rlast,
    input  logic                             rvalid,
    input  logic [1:0]                       rresp,
    output logic                             rready,
    output logic [3:0]                       awid,
    output logic [31:0]                      awaddr,
    output logic [7:0]                       awlen,
    output logic [2:0]                       awsize,
    output logic [1:0]                       awburst,
    output logic                             awvalid,
    input  logic                             awready,
    output logic [31:0]                      wdata,
    output logic [3:0]                       wstrb,
    output logic                             wlast,
    output logic                             wvalid,
    input  logic                             wready,
    input  logic                             bvalid,
    input  logic [1:0]                       bresp,
    output logic                             bready
);

    state_t                        state;
    logic [2:0]                    cnt;
    logic                          turn;
    logic [LINE_WORDS-1:0][31:0]   wr_line;
    logic                          take_wr;
    logic                          take_rd;

    assign arid    = AXI_ID;
    assign awid    = AXI_ID;
    assign arlen   = AXI_LEN_LINE;
    assign awlen   = AXI_LEN_LINE;
    assign arsize  = AXI_SIZE_4B;
    assign awsize  = AXI_SIZE_4B;
    assign arburst = AXI_BURST_INCR;
    assign awburst = AXI_BURST_INCR;
    assign wstrb   = 4'hF;

    // Completion and the response beat count are tracked by our own counter,
    // so the slave's rlast and response codes carry no information we use.
    logic unused_inputs;
    assign unused_inputs = ^{rlast, rresp, bresp,
                             mem_addr[OFFSET_LEN-1:0], wr_addr[OFFSET_LEN-1:0]};

    assign take_wr = (state == ST_IDLE) && !turn && mem_write_req;
    assign take_rd = (state == ST_IDLE) && !turn && !mem_write_req && mem_read_req;

    always_ff @(posedge clk) begin
        if (take_wr)
            wr_line <= axi_wr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 3'd0;
            turn      <= 1'b0;
            mass_data <= '0;
            mem_gnt   <= 1'b0;
            wr_done   <= 1'b0;
            araddr    <= 32'd0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            awaddr    <= 32'd0;
            awvalid   <= 1'b0;
            wdata     <= 32'd0;
            wlast     <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // The cycle after a done pulse is a dead cycle so a request
                    // the cache has not yet dropped is not taken twice.
                    turn <= 1'b0;
                    if (take_wr) begin
                        awaddr  <= {wr_addr[31:OFFSET_LEN], {OFFSET_LEN{1'b0}}};
                        awvalid <= 1'b1;
                        state   <= ST_AW;
                    end else if (take_rd) begin
                        araddr  <= {mem_addr[31:OFFSET_LEN], {OFFSET_LEN{1'b0}}};
                        arvalid <= 1'b1;
                        state   <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        cnt     <= 3'd0;
                        state   <= ST_R;
                    end
                end
                ST_R: begin
                    if (rvalid) begin
                        mass_data[cnt] <= rdata;
                        if (cnt == LAST_BEAT) begin
                            rready  <= 1'b0;
                            mem_gnt <= 1'b1;
                            cnt     <= 3'd0;
                            state   <= ST_RD_DONE;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end
                ST_RD_DONE: begin
                    mem_gnt <= 1'b0;
                    turn    <= 1'b1;
                    state   <= ST_IDLE;
                end
                ST_AW: begin
                    if (awready) begin
                        awvalid <= 1'b0;
                        wvalid  <= 1'b1;
                        wdata   <= wr_line[0];
                        wlast   <= 1'b0;
                        cnt     <= 3'd0;
                        state   <= ST_W;
                    end
                end
                ST_W: begin
                    if (wready) begin
                        if (cnt == LAST_BEAT) begin
                            wvalid <= 1'b0;
                            wlast  <= 1'b0;
                            bready <= 1'b1;
                            cnt    <= 3'd0;
                            state  <= ST_B;
                        end else begin
                            cnt   <= cnt + 3'd1;
                            wdata <= wr_line[cnt + 3'd1];
                            wlast <= ((cnt + 3'd1) == LAST_BEAT);
                        end
                    end
                end
                ST_B: begin
                    if (bvalid) begin
                        bready  <= 1'b0;
                        wr_done <= 1'b1;
                        state   <= ST_WR_DONE;
                    end
                end
                ST_WR_DONE: begin
                    wr_done <= 1'b0;
                    turn    <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/dcache_axi_bridge.md
# dcache_axi_bridge

Memory-side bridge for the data cache: converts the cache's line-refill request (8-word line) and dirty-line writeback request into AXI4 INCR bursts. Sits directly downstream of the data cache and upstream of the AXI interconnect. Returns the refilled line as a parallel 8-word array with a one-cycle grant pulse, matching the cache's SWAP_IN/SWAP_IN_FINISHED handshake.

## Interface
- OFFSET_LEN, 5, line offset bits; line = 2^(OFFSET_LEN-2) = 8 words.
- AXI_ID, 4'd1, fixed ID driven on arid/awid.
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- mem_read_req  in  1  refill request, level, held by the cache until mem_gnt.
- mem_addr  in  32  refill address; low OFFSET_LEN bits ignored.
- mass_data  out  32 x 8  refilled line, word i = address base+4i.
- mem_gnt  out  1  one-cycle pulse: mass_data complete and valid.
- mem_write_req  in  1  writeback request, level, held until wr_done.
- wr_addr  in  32  writeback line address; low bits ignored.
- axi_wr  in  32 x 8  dirty line, sampled when the request is accepted.
- wr_done  out  1  one-cycle pulse after write response.
- arid/araddr/arlen/arsize/arburst/arvalid  out  4/32/8/3/2/1; arready in 1.
- rdata/rlast/rvalid  in  32/1/1; rresp in 2; rready out 1.
- awid/awaddr/awlen/awsize/awburst/awvalid  out  4/32/8/3/2/1; awready in 1.
- wdata/wstrb/wlast/wvalid  out  32/4/1/1; wready in 1.
- bvalid  in 1; bresp in 2; bready out 1.

## Operation
- Constant fields: arlen=awlen=7, arsize=awsize=3'b010, burst=2'b01 (INCR), wstrb=4'hF; addresses = {addr[31:OFFSET_LEN], 0}.
- States: IDLE, AR, R, RD_DONE, AW, W, B, WR_DONE.
- IDLE: mem_write_req has priority → latch wr_addr, axi_wr → AW; else mem_read_req → latch mem_addr → AR.
- AR: arvalid=1 until arready, then R. Address/valid stable while waiting.
- R: rready=1; each rvalid beat stores rdata into mass_data[cnt], cnt++; on 8th beat (cnt==7) → RD_DONE. rlast and rresp not checked (rlast is ignored, count is authoritative).
- RD_DONE: mem_gnt=1 for exactly one cycle → IDLE. mass_data holds until the next read burst's first beat.
- AW: awvalid=1 until awready → W.
- W: wvalid=1, wdata=latched line[cnt], wlast=(cnt==7); advance on wready; after 8th beat → B.
- B: bready=1; on bvalid → WR_DONE. bresp ignored.
- WR_DONE: wr_done=1 one cycle → IDLE.
- Requests are sampled only in IDLE; a request still high in the cycle after a done pulse is ignored (IDLE adds one turnaround cycle first).
- Reset (any time, including mid-burst): state IDLE, cnt 0, all valid/ready/done outputs 0, mass_data all 0, address regs 0. Outstanding AXI transactions are abandoned; the interconnect is reset together.

## Timing
- Read, zero-wait-state slave: req sampled cycle 0 → arvalid cycle 1; arready cycle 1 → R cycles 2–9 (back-to-back beats) → mem_gnt cycle 10.
- Write, zero-wait-state: awvalid cycle 1, W beats cycles 2–9, bready from cycle 10, bvalid cycle 10 → wr_done cycle 11.
- rvalid gaps and wready stalls stretch R/W without losing or duplicating beats.
- Simultaneous read and write requests in IDLE: write burst completes fully, then read is taken from IDLE.
- All outputs registered; no combinational path from AXI inputs to AXI outputs.

## Structure
- Package dcache_axi_pkg: state enum, LINE_WORDS, AXI_BURST_INCR=2'b01, AXI_SIZE_4B=3'b010, AXI_LEN_LINE=8'd7.
- One 3-bit beat counter shared by R and W; no sub-module required.

## Test plan
- Read, zero wait: mem_addr=0x1000_0024, rdata 0xA0..0xA7 → araddr=0x1000_0020, arlen=7, mass_data[i]=0xA0+i, mem_gnt at cycle 10, one cycle wide.
- Read with arready delayed 3 cycles and rvalid low every other cycle → same data, no extra beats, gnt after 8th beat.
- Write: wr_addr=0x2000_0040, line 0xB0..0xB7, wready stalls beat 3 for 2 cycles → wdata order 0xB0..0xB7, wlast only on 0xB7, wr_done one cycle after bvalid.
- Both requests asserted in same cycle → complete AW/W/B burst before arvalid rises.
- rst asserted during R after 4 beats → all outputs 0 next edge, mass_data cleared; new read afterwards completes normally.
- Request held high after mem_gnt → exactly one burst issued before cache deasserts.
